// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
// Provides the owner encoding used to tag commands travelling down the
// pipeline, the RAM read/write encoding and the default bus widths.
package mem_pkg;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_rw_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with lock override.
// Ports:
//   req_fetch, req_data  - qualified requests (already masked by reset)
//   locked               - data port holds the RAM; fetch cannot be granted
//   fetch_prio           - a lock just expired; fetch wins the next contention
//   last_owner           - port granted most recently
//   gnt_fetch, gnt_data  - one-hot (or zero) grant for this cycle
//   next_owner           - value for last_owner after this cycle
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic   req_fetch,
    input  logic   req_data,
    input  logic   locked,
    input  logic   fetch_prio,
    input  owner_t last_owner,
    output logic   gnt_fetch,
    output logic   gnt_data,
    output owner_t next_owner
);

    logic fetch_ok;

    assign fetch_ok = req_fetch & ~locked;

    always_comb begin
        gnt_fetch  = 1'b0;
        gnt_data   = 1'b0;
        next_owner = last_owner;
        if (fetch_ok && req_data) begin
            // Contention: the port that did not win last time goes now,
            // unless an expired lock owes fetch a turn.
            if (fetch_prio || last_owner == OWN_DATA) begin
                gnt_fetch = 1'b1;
            end else begin
                gnt_data = 1'b1;
            end
        end else if (fetch_ok) begin
            gnt_fetch = 1'b1;
        end else if (req_data) begin
            gnt_data = 1'b1;
        end
        if (gnt_fetch) begin
            next_owner = OWN_FETCH;
        end else if (gnt_data) begin
            next_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port, word-addressed RAM between the instruction-fetch
// path and the load/store path. Grants are combinational; the winner is
// registered onto the RAM ports (command stage), and one cycle later the
// owner tag is registered again so it lines up with the RAM's registered
// read data (response stage). Fixed two-cycle grant-to-rvalid latency.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   if_req/if_a                 - fetch read request and address
//   if_gnt/if_rvalid/if_rdata   - fetch accept, read valid, read data
//   d_req/d_rw/d_a/d_din/d_lock - data request, write flag, address,
//                                 write data, hold-RAM-after-grant
//   d_gnt/d_rvalid/d_rdata      - data accept, completion, read data
//   ram_a/ram_din/ram_rw        - registered RAM command
//   ram_dout                    - RAM registered read data
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_a,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_a,
    input  logic [DW-1:0] d_din,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    output logic          ram_rw,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    owner_t     last_owner;
    owner_t     next_owner;
    owner_t     cmd_owner;
    owner_t     rsp_owner;
    logic       cmd_valid;
    logic       rsp_valid;
    logic       locked;
    logic       fetch_prio;
    logic [7:0] lock_cnt;
    logic       lock_expire;
    logic       gnt_fetch;
    logic       gnt_data;

    rr_arbiter2 u_arb (
        .req_fetch  (if_req & ~rst),
        .req_data   (d_req & ~rst),
        .locked     (locked),
        .fetch_prio (fetch_prio),
        .last_owner (last_owner),
        .gnt_fetch  (gnt_fetch),
        .gnt_data   (gnt_data),
        .next_owner (next_owner)
    );

    assign if_gnt = gnt_fetch;
    assign d_gnt  = gnt_data;

    // The lock ends on the cycle the counter would reach the limit, so fetch
    // is blocked for at most LOCK_MAX consecutive locked cycles.
    assign lock_expire = locked && ((lock_cnt + 8'd1) == LOCK_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_FETCH;
            cmd_valid  <= 1'b0;
            cmd_owner  <= OWN_FETCH;
            rsp_valid  <= 1'b0;
            rsp_owner  <= OWN_FETCH;
            ram_a      <= '0;
            ram_din    <= '0;
            ram_rw     <= MEM_READ;
            locked     <= 1'b0;
            fetch_prio <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            last_owner <= next_owner;

            // Command stage
            cmd_valid <= gnt_fetch | gnt_data;
            if (gnt_fetch) begin
                cmd_owner <= OWN_FETCH;
                ram_a     <= if_a;
                ram_rw    <= MEM_READ;
            end else if (gnt_data) begin
                cmd_owner <= OWN_DATA;
                ram_a     <= d_a;
                ram_din   <= d_din;
                ram_rw    <= d_rw;
            end else begin
                ram_rw <= MEM_READ;
            end

            // Response stage
            rsp_valid <= cmd_valid;
            rsp_owner <= cmd_owner;

            // Lock tracking. Expiry beats a same-cycle re-arm, and re-arming
            // stays blocked until fetch has had its owed turn.
            if (lock_expire) begin
                locked     <= 1'b0;
                fetch_prio <= 1'b1;
                lock_cnt   <= LOCK_LIMIT;
            end else begin
                if (locked && lock_cnt != LOCK_LIMIT) begin
                    lock_cnt <= lock_cnt + 8'd1;
                end
                if (gnt_data) begin
                    if (!d_lock) begin
                        locked <= 1'b0;
                    end else if (!locked && !fetch_prio) begin
                        locked   <= 1'b1;
                        lock_cnt <= '0;
                    end
                end
            end
            if (gnt_fetch) begin
                fetch_prio <= 1'b0;
            end
        end
    end

    assign if_rvalid = rsp_valid && (rsp_owner == OWN_FETCH);
    assign d_rvalid  = rsp_valid && (rsp_owner == OWN_DATA);
    assign if_rdata  = ram_dout;
    assign d_rdata   = ram_dout;

endmodule
